// File: rtl/frame_writer.sv
// Frame RAM write engine: turns pixel / filled-rect / clear commands into a
// row-major stream of single colour-index writes, one per clock.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a command; cmd_ready high
// S_CHECK | validate latched command, register base address or pulse err
// S_DRAW  | one write per non-stalled cycle until the last pixel (done)
module frame_writer #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int ADDR_W  = 19,
   parameter int COLOR_W = 8
) (
   input  logic               iVGA_CLK,
   input  logic               iRST_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [9:0]         cmd_x0,
   input  logic [8:0]         cmd_y0,
   input  logic [9:0]         cmd_x1,
   input  logic [8:0]         cmd_y1,
   input  logic [COLOR_W-1:0] cmd_color,
   input  logic               stall,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [COLOR_W-1:0] wr_data,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [1:0] OP_PIXEL = 2'b00;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   localparam int unsigned H_LIM = H_RES;
   localparam int unsigned V_LIM = V_RES;
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DRAW} state_t;

   state_t state_q, state_d;

   logic [1:0]         op_q;
   logic [9:0]         x0_q, x1_q, cx_q;
   logic [8:0]         y0_q, y1_q, cy_q;
   logic [COLOR_W-1:0] color_q, hold_data;
   logic [ADDR_W-1:0]  cur_addr, row_step, hold_addr;

   logic       accept;
   logic       cmd_ok;
   logic       row_end;
   logic       last_px;
   logic [9:0] dx;

   assign cmd_ok  = (op_q != OP_RSVD) &&
                    (x0_q <= x1_q) && (32'(x1_q) < H_LIM) &&
                    (y0_q <= y1_q) && (32'(y1_q) < V_LIM);
   assign row_end = (cx_q == x1_q);
   assign last_px = row_end && (cy_q == y1_q);
   assign dx      = x1_q - x0_q;

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);

   // Outputs show the held values of the previous write whenever wr_en is low
   assign wr_addr = wr_en ? cur_addr : hold_addr;
   assign wr_data = wr_en ? color_q  : hold_data;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      wr_en   = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               accept  = 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (cmd_ok) begin
               state_d = S_DRAW;
            end else begin
               err     = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DRAW: begin
            if (!stall) begin
               wr_en = 1'b1;
               if (last_px) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         op_q      <= '0;
         x0_q      <= '0;
         y0_q      <= '0;
         x1_q      <= '0;
         y1_q      <= '0;
         color_q   <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         cur_addr  <= '0;
         row_step  <= '0;
         hold_addr <= '0;
         hold_data <= '0;
      end else begin
         if (accept) begin
            op_q    <= cmd_op;
            color_q <= cmd_color;
            if (cmd_op == OP_CLEAR) begin
               x0_q <= '0;
               y0_q <= '0;
               x1_q <= 10'(H_RES - 1);
               y1_q <= 9'(V_RES - 1);
            end else if (cmd_op == OP_PIXEL) begin
               x0_q <= cmd_x0;
               y0_q <= cmd_y0;
               x1_q <= cmd_x0;
               y1_q <= cmd_y0;
            end else begin
               x0_q <= cmd_x0;
               y0_q <= cmd_y0;
               x1_q <= cmd_x1;
               y1_q <= cmd_y1;
            end
         end

         // The only multiply: once per command, never per pixel
         if (state_q == S_CHECK && cmd_ok) begin
            cur_addr <= ADDR_W'(y0_q) * H_STEP + ADDR_W'(x0_q);
            row_step <= H_STEP - ADDR_W'(dx);
            cx_q     <= x0_q;
            cy_q     <= y0_q;
         end

         if (wr_en) begin
            hold_addr <= cur_addr;
            hold_data <= color_q;
            if (!last_px) begin
               if (row_end) begin
                  cur_addr <= cur_addr + row_step;
                  cx_q     <= x0_q;
                  cy_q     <= cy_q + 9'd1;
               end else begin
                  cur_addr <= cur_addr + 1'b1;
                  cx_q     <= cx_q + 10'd1;
               end
            end
         end
      end
   end

endmodule
